// File: rtl/debounce_pkg.sv
// Shared types and constants for the button debouncer / auto-repeat pulse generator.
package debounce_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        REPEAT,
        RELEASE_WAIT
    } state_e;

    localparam int MIN_STABLE_CYCLES = 2;
    // Hold and repeat periods below 2 would let two strobes land on back-to-back cycles.
    localparam int MIN_PERIOD_CYCLES = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the raw button level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/debounce_pulse_gen.sv
// Debounces a raw button and emits single-cycle decrement strobes: one per accepted
// press, then auto-repeat strobes while the button stays held.
module debounce_pulse_gen
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 50,
    parameter int REPEAT_CYCLES = 10,
    parameter int REPEAT_EN     = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level_out,
    output logic pulse_out
);

    localparam int STABLE_EFF = (STABLE_CYCLES < MIN_STABLE_CYCLES) ? MIN_STABLE_CYCLES : STABLE_CYCLES;
    localparam int HOLD_EFF   = (HOLD_CYCLES < MIN_PERIOD_CYCLES) ? MIN_PERIOD_CYCLES : HOLD_CYCLES;
    localparam int REPEAT_EFF = (REPEAT_CYCLES < MIN_PERIOD_CYCLES) ? MIN_PERIOD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W      = $clog2(max3(STABLE_EFF, HOLD_EFF, REPEAT_EFF) + 1);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] STABLE_C    = CNT_W'(STABLE_EFF);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_EFF - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_EFF - 1);

    logic             sync_q;
    state_e           state_q;
    logic [CNT_W-1:0] stableCnt_q;
    logic [CNT_W-1:0] holdCnt_q;
    logic [CNT_W-1:0] repeatCnt_q;
    logic             level_q;
    logic             pulse_q;
    logic [CNT_W-1:0] stableCnt_d;
    logic [CNT_W-1:0] holdCnt_d;
    logic [CNT_W-1:0] repeatCnt_d;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (sync_q)
    );

    // Saturating increments so a stuck button can never wrap a counter back to a trigger value.
    always_comb begin
        stableCnt_d = (stableCnt_q == CNT_MAX) ? stableCnt_q : stableCnt_q + CNT_ONE;
        holdCnt_d   = (holdCnt_q   == CNT_MAX) ? holdCnt_q   : holdCnt_q   + CNT_ONE;
        repeatCnt_d = (repeatCnt_q == CNT_MAX) ? repeatCnt_q : repeatCnt_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            stableCnt_q <= '0;
            holdCnt_q   <= '0;
            repeatCnt_q <= '0;
            level_q     <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sync_q) begin
                        state_q     <= PRESS_WAIT;
                        stableCnt_q <= CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync_q) begin
                        state_q     <= IDLE;
                        stableCnt_q <= '0;
                    end else if (stableCnt_q >= STABLE_C) begin
                        state_q     <= PRESSED;
                        stableCnt_q <= '0;
                        holdCnt_q   <= '0;
                        level_q     <= 1'b1;
                        pulse_q     <= 1'b1;
                    end else begin
                        stableCnt_q <= stableCnt_d;
                    end
                end
                PRESSED: begin
                    if (!sync_q) begin
                        state_q     <= RELEASE_WAIT;
                        stableCnt_q <= CNT_ONE;
                    end else if ((REPEAT_EN != 0) && (holdCnt_q == HOLD_LAST)) begin
                        state_q     <= REPEAT;
                        repeatCnt_q <= '0;
                        pulse_q     <= 1'b1;
                    end else begin
                        holdCnt_q <= holdCnt_d;
                    end
                end
                REPEAT: begin
                    if (!sync_q) begin
                        state_q     <= RELEASE_WAIT;
                        stableCnt_q <= CNT_ONE;
                    end else if (repeatCnt_q == REPEAT_LAST) begin
                        repeatCnt_q <= '0;
                        pulse_q     <= 1'b1;
                    end else begin
                        repeatCnt_q <= repeatCnt_d;
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back high resumes the press without a strobe; the hold delay starts over.
                    if (sync_q) begin
                        state_q     <= PRESSED;
                        stableCnt_q <= '0;
                        holdCnt_q   <= '0;
                    end else if (stableCnt_d >= STABLE_C) begin
                        state_q     <= IDLE;
                        stableCnt_q <= '0;
                        level_q     <= 1'b0;
                    end else begin
                        stableCnt_q <= stableCnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign level_out = level_q;
    assign pulse_out = pulse_q;

endmodule

// File: doc/debounce_pulse_gen.md
DEBOUNCE_PULSE_GEN -- requirements
Module: debounce_pulse_gen

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, giving the consecutive synchronized samples required to accept an input change (minimum 2).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 50, giving the cycles in PRESSED before the first auto-repeat pulse.
REQ-003 The block SHALL have parameter REPEAT_CYCLES, default 10, giving the pulse period in REPEAT.
REQ-004 The block SHALL have parameter REPEAT_EN, default 1; 0 disables auto-repeat.
REQ-005 Port list SHALL be:
  clk        input   1  single clock; all state changes on rising edge
  reset      input   1  synchronous, active-high reset
  btn_in     input   1  raw asynchronous button level, active-high
  level_out  output  1  debounced button level
  pulse_out  output  1  single-cycle decrement strobe for the downstream down-counter

Function
REQ-006 btn_in SHALL pass through a two-flop synchronizer; all decisions SHALL use only the second-flop value, sync_q.
REQ-007 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED, REPEAT, RELEASE_WAIT.
REQ-008 IDLE: sync_q=1 -> PRESS_WAIT with stability count 1; otherwise stay.
REQ-009 PRESS_WAIT: sync_q=1 increments the count; sync_q=0 -> IDLE with count cleared; when the count reaches STABLE_CYCLES, the next state SHALL be PRESSED.
REQ-010 On entry to PRESSED from PRESS_WAIT, level_out SHALL go 1 and pulse_out SHALL be 1 for exactly one cycle.
REQ-011 Latency: with btn_in held high, pulse_out SHALL be high after the edge that is STABLE_CYCLES+2 edges after the first edge sampling btn_in high.
REQ-012 PRESSED: hold counter increments each cycle; with REPEAT_EN=1 and count=HOLD_CYCLES, one pulse is issued and the state moves to REPEAT.
REQ-013 REPEAT: one pulse SHALL be issued every REPEAT_CYCLES cycles while sync_q=1.
REQ-014 PRESSED or REPEAT with sync_q=0 SHALL go to RELEASE_WAIT with count 1; level_out stays 1; no pulse.
REQ-015 RELEASE_WAIT: sync_q=0 increments; reaching STABLE_CYCLES -> IDLE with level_out=0; sync_q=1 before that -> PRESSED with hold counter restarted and no pulse.
REQ-016 pulse_out SHALL never be high on two consecutive cycles; a glitch shorter than STABLE_CYCLES SHALL produce no pulse and no level_out change.
REQ-017 Counters SHALL saturate and never wrap; widths SHALL be $clog2(max parameter + 1).
REQ-018 Outputs SHALL be registered (no combinational path from btn_in).

Reset
REQ-019 reset=1 at a rising edge SHALL force IDLE, all counters 0, both synchronizer flops 0, level_out=0, pulse_out=0.
REQ-020 Reset mid-press SHALL discard progress; after reset deassertion, a still-held button SHALL be treated as a new press with full REQ-011 latency.

Structure
REQ-021 The FSM state enum and the minimum-STABLE_CYCLES constant SHALL live in the shared package debounce_pkg.
REQ-022 The synchronizer SHALL be the separate sub-module sync_2ff (clk, reset, d, q).

Verification (STABLE_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=3)
REQ-023 Clean press: btn_in 0->1 held 30 cycles -> single pulse 6 edges after first high sample; level_out=1; then pulses at hold expiry and every 3 cycles.
REQ-024 Glitch: btn_in high for 3 cycles then low -> no pulse, level_out stays 0.
REQ-025 Bounce on release: low 2 cycles, high 1, low 10 -> level_out drops only after 4 stable lows; no extra pulse.
REQ-026 REPEAT_EN=0, held 40 cycles -> exactly one pulse total.
REQ-027 Reset asserted in REPEAT with btn held -> next cycle pulse_out=0, level_out=0; after deassert, new pulse after 6 edges.
REQ-028 Integration: connect pulse_out to a 2-bit down-counter decrement loaded with 3; press 3 times -> counter reads 2, 1, 0.
